// File: rtl/fixed_dot3.sv
// Signed fixed-point three-element dot product. Inputs are registered, the products go through a
// MUL_STAGES-deep register chain, then an exact sum stage, then a round/shift/saturate output stage.
module fixed_dot3 #(
   parameter int D          = 8,
   parameter int Q          = 24,
   parameter int ROUND      = 0,
   parameter int MUL_STAGES = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic                   new_data,
   input  logic signed [D+Q-1:0]  ax,
   input  logic signed [D+Q-1:0]  ay,
   input  logic signed [D+Q-1:0]  az,
   input  logic signed [D+Q-1:0]  bx,
   input  logic signed [D+Q-1:0]  by,
   input  logic signed [D+Q-1:0]  bz,
   output logic signed [D+Q-1:0]  r,
   output logic                   sat,
   output logic                   output_valid
);

   localparam int W  = D + Q;
   localparam int PW = 2 * W;
   localparam int SW = 2 * W + 2;

   localparam logic signed [SW-1:0] RND_ADD = (ROUND != 0) ? (SW'(1) << (Q - 1)) : '0;
   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

   // NOTE: only the valid bits and the outputs are reset; the wide datapath registers are
   // not, since their contents are ignored until a valid bit reaches the output.
   logic signed [W-1:0]  a_q [3] = '{default: '0};
   logic signed [W-1:0]  b_q [3] = '{default: '0};
   logic signed [PW-1:0] px_q [MUL_STAGES] = '{default: '0};
   logic signed [PW-1:0] py_q [MUL_STAGES] = '{default: '0};
   logic signed [PW-1:0] pz_q [MUL_STAGES] = '{default: '0};
   logic signed [SW-1:0] sum_q = '0;

   logic                  in_v_q  = 1'b0;
   logic [MUL_STAGES-1:0] mv_q    = '0;
   logic                  sum_v_q = 1'b0;
   logic                  ov_q    = 1'b0;
   logic signed [W-1:0]   r_q     = '0;
   logic                  sat_q   = 1'b0;

   logic signed [SW-1:0]  rounded_d;
   logic signed [SW-1:0]  shifted_d;
   logic signed [W-1:0]   r_d;
   logic                  sat_d;

   always_ff @(posedge clk) begin
      if (ce) begin
         a_q <= '{ax, ay, az};
         b_q <= '{bx, by, bz};
      end
   end

   always_ff @(posedge clk) begin
      if (ce) begin
         px_q[0] <= PW'(a_q[0]) * PW'(b_q[0]);
         py_q[0] <= PW'(a_q[1]) * PW'(b_q[1]);
         pz_q[0] <= PW'(a_q[2]) * PW'(b_q[2]);
         for (int i = 1; i < MUL_STAGES; i++) begin
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
            pz_q[i] <= pz_q[i-1];
         end
         sum_q <= SW'(px_q[MUL_STAGES-1]) + SW'(py_q[MUL_STAGES-1]) + SW'(pz_q[MUL_STAGES-1]);
      end
   end

   // Valid bits march with the data; reset wins over ce so in-flight work is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_v_q  <= 1'b0;
         mv_q    <= '0;
         sum_v_q <= 1'b0;
         ov_q    <= 1'b0;
         r_q     <= '0;
         sat_q   <= 1'b0;
      end else if (ce) begin
         in_v_q  <= new_data;
         mv_q    <= MUL_STAGES'({mv_q, in_v_q});
         sum_v_q <= mv_q[MUL_STAGES-1];
         ov_q    <= sum_v_q;
         r_q     <= r_d;
         sat_q   <= sat_d;
      end
   end

   // NOTE: every combinational output gets a default first so no latch can be inferred.
   always_comb begin
      rounded_d = sum_q + RND_ADD;
      shifted_d = rounded_d >>> Q;
      r_d       = shifted_d[W-1:0];
      sat_d     = 1'b0;
      if (shifted_d > SAT_MAX) begin
         r_d   = SAT_MAX[W-1:0];
         sat_d = 1'b1;
      end else if (shifted_d < SAT_MIN) begin
         r_d   = SAT_MIN[W-1:0];
         sat_d = 1'b1;
      end
   end

   assign r            = r_q;
   assign sat          = sat_q;
   assign output_valid = ov_q;

endmodule
